// File: rtl/ps2_key_events_pkg.sv
// Shared game constants: PS/2 prefix bytes, default key codes and the
// scan-code decoder state encoding.
package ps2_key_events_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam logic [7:0] KEY_P1_CODE    = 8'h1C;
  localparam logic [7:0] KEY_P2_CODE    = 8'h4B;
  localparam logic [7:0] KEY_START_CODE = 8'h5A;

  localparam int unsigned TIMEOUT_CNT_W = 21;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

endpackage

// File: rtl/ps2_key_events_key_tracker.sv
// Per-key held/press tracker: one press pulse per physical press,
// typematic repeats and presses made while disabled never pulse.
module key_tracker (
  input  logic clk,
  input  logic rst,
  input  logic make,
  input  logic brk,
  input  logic en,
  output logic held,
  output logic press
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      held  <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (make && !held) begin
        held  <= 1'b1;
        press <= en;
      end else if (brk) begin
        held  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_events.sv
// PS/2 scan-code decoder for the three game keys: make/break/extended
// prefix FSM, prefix timeout and per-key press/held tracking.
module ps2_key_events
  import ps2_key_events_pkg::*;
#(
  parameter logic [7:0]  P1_CODE     = KEY_P1_CODE,
  parameter logic [7:0]  P2_CODE     = KEY_P2_CODE,
  parameter logic [7:0]  START_CODE  = KEY_START_CODE,
  parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       en,
  output logic       p1_press,
  output logic       p2_press,
  output logic       start_press,
  output logic       p1_held,
  output logic       p2_held,
  output logic       start_held,
  output logic       seq_err
);

  localparam logic [TIMEOUT_CNT_W-1:0] CNT_LAST = TIMEOUT_CNT_W'(TIMEOUT_CYC - 1);

  ps2_state_t state_q, state_d;
  logic [TIMEOUT_CNT_W-1:0] cnt_q;
  logic timeout;
  logic is_make, is_brk;
  logic p1_make, p2_make, start_make;
  logic p1_brk, p2_brk, start_brk;

  // A byte arriving in the expiry cycle takes precedence over the timeout.
  assign timeout = (state_q != ST_IDLE) && !byte_valid && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    state_d = state_q;
    if (byte_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (byte_in == PS2_BREAK)    state_d = ST_BRK;
          else if (byte_in == PS2_EXT) state_d = ST_EXT;
        end
        ST_BRK:     state_d = ST_IDLE;
        ST_EXT:     state_d = (byte_in == PS2_BREAK) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_d = ST_IDLE;
    end
  end

  // Output logic: make/break strobes for non-extended codes only
  always_comb begin
    is_make = 1'b0;
    is_brk  = 1'b0;
    if (byte_valid) begin
      unique case (state_q)
        ST_IDLE: is_make = (byte_in != PS2_BREAK) && (byte_in != PS2_EXT);
        ST_BRK:  is_brk  = 1'b1;
        default: ;
      endcase
    end
  end

  assign p1_make    = is_make && (byte_in == P1_CODE);
  assign p2_make    = is_make && (byte_in == P2_CODE);
  assign start_make = is_make && (byte_in == START_CODE);
  assign p1_brk     = is_brk  && (byte_in == P1_CODE);
  assign p2_brk     = is_brk  && (byte_in == P2_CODE);
  assign start_brk  = is_brk  && (byte_in == START_CODE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      seq_err <= 1'b0;
    end else begin
      seq_err <= timeout;
      if (byte_valid || timeout || state_q == ST_IDLE) cnt_q <= '0;
      else                                             cnt_q <= cnt_q + 1'b1;
    end
  end

  key_tracker u_p1 (
    .clk   (clk),
    .rst   (rst),
    .make  (p1_make),
    .brk   (p1_brk),
    .en    (en),
    .held  (p1_held),
    .press (p1_press)
  );

  key_tracker u_p2 (
    .clk   (clk),
    .rst   (rst),
    .make  (p2_make),
    .brk   (p2_brk),
    .en    (en),
    .held  (p2_held),
    .press (p2_press)
  );

  key_tracker u_start (
    .clk   (clk),
    .rst   (rst),
    .make  (start_make),
    .brk   (start_brk),
    .en    (en),
    .held  (start_held),
    .press (start_press)
  );

endmodule

// File: tb/tb_ps2_key_events.sv
// Self-checking bench for ps2_key_events: directed scenarios followed by
// randomized byte streams against a prefix-queue reference model.
module tb_ps2_key_events;

  localparam int T = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       en = 1'b0;
  logic       p1_press, p2_press, start_press;
  logic       p1_held, p2_held, start_held;
  logic       seq_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit        m_held  [3];
  bit        m_press [3];
  bit        m_err;
  logic [7:0] prefix [$];
  int        idle;

  always #5 clk = ~clk;

  ps2_key_events #(.TIMEOUT_CYC(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .en          (en),
    .p1_press    (p1_press),
    .p2_press    (p2_press),
    .start_press (start_press),
    .p1_held     (p1_held),
    .p2_held     (p2_held),
    .start_held  (start_held),
    .seq_err     (seq_err)
  );

  function automatic int key_idx(input logic [7:0] b);
    case (b)
      8'h1C:   return 0;
      8'h4B:   return 1;
      8'h5A:   return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [7:0] b, input bit e);
    int k;
    for (int i = 0; i < 3; i++) m_press[i] = 1'b0;
    m_err = 1'b0;
    if (!r) begin
      for (int i = 0; i < 3; i++) m_held[i] = 1'b0;
      prefix.delete();
      idle = 0;
    end else if (v) begin
      idle = 0;
      k = key_idx(b);
      if (prefix.size() == 0) begin
        if (b == 8'hF0 || b == 8'hE0) prefix.push_back(b);
        else if (k >= 0 && !m_held[k]) begin
          m_held[k]  = 1'b1;
          m_press[k] = e;
        end
      end else if (prefix.size() == 1 && prefix[0] == 8'hF0) begin
        if (k >= 0) m_held[k] = 1'b0;
        prefix.delete();
      end else if (prefix.size() == 1 && b == 8'hF0) begin
        prefix.push_back(b);
      end else begin
        prefix.delete();
      end
    end else if (prefix.size() != 0) begin
      idle++;
      if (idle == T) begin
        prefix.delete();
        idle  = 0;
        m_err = 1'b1;
      end
    end
  endtask

  task automatic apply(input bit r, input bit v, input logic [7:0] b, input bit e, input string tag);
    logic [6:0] got, exp;
    rst = r; byte_valid = v; byte_in = b; en = e;
    model_step(r, v, b, e);
    @(posedge clk);
    #1;
    got = {p1_press, p2_press, start_press, p1_held, p2_held, start_held, seq_err};
    exp = {m_press[0], m_press[1], m_press[2], m_held[0], m_held[1], m_held[2], m_err};
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed press/held/err=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit e, input string tag);
    apply(1'b1, 1'b1, b, e, tag);
  endtask

  task automatic wait_idle(input int n, input bit e, input string tag);
    for (int i = 0; i < n; i++) apply(1'b1, 1'b0, 8'h00, e, tag);
  endtask

  initial begin
    logic [7:0] b;
    bit r, v, e;
    prefix.delete();
    idle = 0;

    // Reset state
    apply(1'b0, 1'b0, 8'h00, 1'b1, "reset0");
    apply(1'b0, 1'b1, 8'h1C, 1'b1, "reset_vs_byte");

    // P1 press, typematic, release
    send(8'h1C, 1'b1, "p1_make");
    for (int i = 0; i < 5; i++) send(8'h1C, 1'b1, "p1_typematic");
    send(8'hF0, 1'b1, "p1_brk_prefix");
    send(8'h1C, 1'b1, "p1_break");
    wait_idle(2, 1'b1, "quiet");

    // Back-to-back makes
    send(8'h1C, 1'b1, "b2b_p1");
    send(8'h4B, 1'b1, "b2b_p2");
    send(8'hF0, 1'b1, "b2b_rel");
    send(8'h1C, 1'b1, "b2b_rel_p1");
    send(8'hF0, 1'b1, "b2b_rel");
    send(8'h4B, 1'b1, "b2b_rel_p2");

    // Extended codes never alias game keys
    send(8'hE0, 1'b1, "ext");
    send(8'h1C, 1'b1, "ext_make");
    send(8'hE0, 1'b1, "ext");
    send(8'hF0, 1'b1, "ext_brk");
    send(8'h1C, 1'b1, "ext_brk_code");
    send(8'h1C, 1'b1, "post_ext_make");
    send(8'hF0, 1'b1, "rel");
    send(8'h1C, 1'b1, "rel_p1");

    // Prefix timeout, then START must be a make
    send(8'hF0, 1'b1, "to_prefix");
    wait_idle(T + 2, 1'b1, "timeout_wait");
    send(8'h5A, 1'b1, "start_after_to");
    send(8'hF0, 1'b1, "rel");
    send(8'h5A, 1'b1, "rel_start");

    // Byte in the expiry cycle wins over the timeout
    send(8'h4B, 1'b1, "p2_for_race");
    send(8'hF0, 1'b1, "race_prefix");
    wait_idle(T - 1, 1'b1, "race_wait");
    send(8'h4B, 1'b1, "race_byte");
    wait_idle(3, 1'b1, "race_after");

    // Press while disabled never pulses until re-pressed
    send(8'h4B, 1'b0, "p2_disabled");
    send(8'h4B, 1'b1, "p2_repeat_en");
    send(8'hF0, 1'b1, "p2_rel");
    send(8'h4B, 1'b1, "p2_rel_code");
    send(8'h4B, 1'b1, "p2_repress");
    send(8'hF0, 1'b1, "rel");
    send(8'h4B, 1'b1, "rel_p2");

    // Reset discards a pending prefix
    send(8'hF0, 1'b1, "rst_prefix");
    apply(1'b0, 1'b0, 8'h00, 1'b1, "mid_reset");
    send(8'h1C, 1'b1, "post_reset_make");

    // Randomized streams with occasional long gaps and resets
    for (int n = 0; n < 2500; n++) begin
      r = ($urandom_range(0, 199) != 0);
      v = ($urandom_range(0, 2) != 0);
      e = ($urandom_range(0, 5) != 0);
      case ($urandom_range(0, 7))
        0, 1:    b = 8'h1C;
        2:       b = 8'h4B;
        3:       b = 8'h5A;
        4:       b = 8'hF0;
        5:       b = 8'hE0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      apply(r, v, b, e, "random");
      if ($urandom_range(0, 39) == 0)
        wait_idle($urandom_range(T - 2, T + 1), e, "random_gap");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
